playbus_sequencer: RTL and testbench
====================================

PLAYBUS_SEQUENCER -- requirements
Module: playbus_sequencer

Interface
REQ-001 Parameter: DEPTH, default 4; command FIFO entries; power of two, 2..16.
REQ-002 Parameter: AW, default 8; bus address width.
REQ-003 clk  input  1  system clock; all state changes on rising edge.
REQ-004 n_reset  input  1  reset; asynchronous and active-low.
REQ-005 cmd_valid  input  1  command offered this cycle.
REQ-006 cmd_func  input  3  PlayBus function code of offered command.
REQ-007 cmd_addr  input  AW  bus address of offered command.
REQ-008 cmd_ready  output  1  sequencer can accept a command this cycle.
REQ-009 func  output  3  function code driven onto PlayBus.
REQ-010 addr  output  AW  address driven onto PlayBus.
REQ-011 busy  output  1  FIFO non-empty or a bus command in progress.
REQ-012 done  output  1  one-cycle pulse on the final bus cycle of each command.
REQ-013 err  output  1  one-cycle pulse when an illegal command is discarded.

Function
REQ-014 A command SHALL be accepted on a rising edge where cmd_valid=1 and cmd_ready=1.
REQ-015 cmd_ready SHALL be 1 exactly when the FIFO holds fewer than DEPTH entries, independent of a same-cycle pop.
REQ-016 Legal codes SHALL be 0-5; an accepted command with code 6 or 7 SHALL be discarded, not queued, and err SHALL pulse high for the cycle after acceptance.
REQ-017 FIFO SHALL be first-in first-out, with read/write pointers wrapping modulo DEPTH and a count of width clog2(DEPTH)+1.
REQ-018 Simultaneous push and pop SHALL leave the count unchanged and preserve order; a pop from an empty FIFO SHALL NOT occur.
REQ-019 The state machine SHALL have states IDLE, ISSUE and HOLD.
REQ-020 IDLE: func=0, addr=last issued address; if the FIFO is non-empty, pop the head and go to ISSUE on the next edge.
REQ-021 ISSUE: func and addr = popped command for exactly one cycle; code 5 -> HOLD; any other code -> IDLE with done=1 in this cycle.
REQ-022 HOLD: func=0, addr held at the code-5 address for one cycle (controller transfer cycle); done=1; next state IDLE.
REQ-023 Latency: a command pushed into an empty idle sequencer SHALL appear on func/addr two edges after acceptance.
REQ-024 Throughput: one non-5 command per 2 cycles; one code-5 command per 3 cycles; IDLE always separates commands.
REQ-025 A queued code 0 SHALL still pass through ISSUE (func=0 for one cycle) and SHALL pulse done.
REQ-026 busy SHALL be 1 whenever count>0 or state is ISSUE or HOLD, else 0.
REQ-027 func and addr SHALL be driven from registers (glitch-free) and SHALL change only on clock edges.

Reset
REQ-028 n_reset=0 SHALL immediately force state IDLE, FIFO empty (pointers and count 0), func=0, addr=0, done=0, err=0, busy=0, cmd_ready=1.
REQ-029 Reset asserted mid-command (ISSUE or HOLD) SHALL abandon that command and all queued entries without pulsing done.
REQ-030 After n_reset rises, the first command SHALL be accepted on the next rising edge with cmd_valid=1.

Verification
REQ-031 Push {func=2, addr=0x12} while idle -> func=2/addr=0x12 for one cycle two edges later, done=1 in that cycle, then func=0.
REQ-032 Push {5,0x40} -> func=5 for one cycle, then func=0 with addr=0x40 and done=1, then IDLE; total 3 cycles.
REQ-033 Push 5 commands back-to-back with DEPTH=4 and sequencer stalled in a code-5 command -> cmd_ready=0 after 4 queued; all issued in order with an IDLE cycle between each.
REQ-034 Push func=6 and func=7 -> err pulses once each, cmd_ready stays 1, bus func remains 0, busy stays 0.
REQ-035 Assert n_reset=0 during HOLD with 2 entries queued -> func=0, addr=0, busy=0 immediately; no done pulse; no queued command issued after release.
REQ-036 Push every cycle while popping, for 20 commands -> no loss or duplication, pointer wrap exercised, count never exceeds DEPTH.

Source files
------------

// File: rtl/playbus_sequencer.sv
// PlayBus command sequencer: a small command FIFO feeding an IDLE/ISSUE/HOLD bus FSM.
// Handshake: a command transfers on a rising edge where cmd_valid=1 and cmd_ready=1.
module playbus_sequencer #(
  parameter int DEPTH = 4,
  parameter int AW    = 8
) (
  input  logic          clk,
  input  logic          n_reset,
  input  logic          cmd_valid,
  input  logic [2:0]    cmd_func,
  input  logic [AW-1:0] cmd_addr,
  output logic          cmd_ready,
  output logic [2:0]    func,
  output logic [AW-1:0] addr,
  output logic          busy,
  output logic          done,
  output logic          err,
  output logic [1:0]    dbg_state
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_HOLD  = 2'd2
  } state_t;

  state_t        r_state;
  state_t        w_state_nxt;
  logic [2:0]    r_mem_func [DEPTH];
  logic [AW-1:0] r_mem_addr [DEPTH];
  logic [PW-1:0] r_wr_ptr;
  logic [PW-1:0] r_rd_ptr;
  logic [CW-1:0] r_count;
  logic [2:0]    r_func;
  logic [2:0]    w_func_nxt;
  logic [AW-1:0] r_addr;
  logic [AW-1:0] w_addr_nxt;
  logic          r_err;
  logic          w_done;
  logic          w_accept;
  logic          w_legal;
  logic          w_push;
  logic          w_pop;

  // Ready looks only at the stored count, so a same-cycle pop never frees a slot early.
  assign cmd_ready = (r_count != CW'(DEPTH));
  assign w_accept  = cmd_valid & cmd_ready;
  assign w_legal   = ~(cmd_func[2] & cmd_func[1]);
  assign w_push    = w_accept & w_legal;
  assign w_pop     = (r_state == S_IDLE) && (r_count != '0);

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem_func[r_wr_ptr] <= cmd_func;
      r_mem_addr[r_wr_ptr] <= cmd_addr;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_func_nxt  = 3'd0;
    w_addr_nxt  = r_addr;
    w_done      = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_pop) begin
          w_state_nxt = S_ISSUE;
          w_func_nxt  = r_mem_func[r_rd_ptr];
          w_addr_nxt  = r_mem_addr[r_rd_ptr];
        end
      end
      S_ISSUE: begin
        // Code 5 needs a controller transfer cycle with the address still on the bus.
        if (r_func == 3'd5) begin
          w_state_nxt = S_HOLD;
        end else begin
          w_state_nxt = S_IDLE;
          w_done      = 1'b1;
        end
      end
      S_HOLD: begin
        w_state_nxt = S_IDLE;
        w_done      = 1'b1;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      r_state <= S_IDLE;
      r_func  <= 3'd0;
      r_addr  <= '0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_func  <= w_func_nxt;
      r_addr  <= w_addr_nxt;
      r_err   <= w_accept & ~w_legal;
    end
  end

  assign func      = r_func;
  assign addr      = r_addr;
  assign done      = w_done;
  assign err       = r_err;
  assign busy      = (r_count != '0) || (r_state != S_IDLE);
  assign dbg_state = r_state;

endmodule

// File: tb/tb_playbus_sequencer.sv
// Bench for playbus_sequencer: directed command streams, a cycle-level bus timeline model
// compared on every falling edge, and literal spot checks on the key scenarios.
module tb_playbus_sequencer;

  localparam int DEPTH = 4;
  localparam int AW    = 8;

  // clock / reset
  logic          clk = 1'b0;
  logic          n_reset = 1'b0;
  logic          cmd_valid = 1'b0;
  logic [2:0]    cmd_func = 3'd0;
  logic [AW-1:0] cmd_addr = '0;
  logic          cmd_ready;
  logic [2:0]    func;
  logic [AW-1:0] addr;
  logic          busy;
  logic          done;
  logic          err;
  logic [1:0]    dbg_state;

  always #5 clk = ~clk;

  playbus_sequencer #(.DEPTH(DEPTH), .AW(AW)) dut (
    .clk       (clk),
    .n_reset   (n_reset),
    .cmd_valid (cmd_valid),
    .cmd_func  (cmd_func),
    .cmd_addr  (cmd_addr),
    .cmd_ready (cmd_ready),
    .func      (func),
    .addr      (addr),
    .busy      (busy),
    .done      (done),
    .err       (err),
    .dbg_state (dbg_state)
  );

  int errors = 0;
  int checks = 0;
  int done_cnt = 0;
  int err_cnt = 0;
  int last_tries = 0;
  bit saw_full = 1'b0;
  int base;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: pending commands plus a timeline of per-cycle bus values still to be shown.
  typedef struct packed {
    logic [2:0]    f;
    logic [AW-1:0] a;
    logic          d;
  } slot_t;

  logic [3+AW-1:0] exp_q[$];
  slot_t           tl[$];
  logic [AW-1:0]   m_last = '0;
  logic            m_err = 1'b0;
  int              m_qn;
  bit              m_idle;
  logic [3+AW-1:0] m_c;

  always @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      exp_q.delete();
      tl.delete();
      m_last = '0;
      m_err  = 1'b0;
    end else begin
      m_qn   = exp_q.size();
      m_idle = (tl.size() == 0);
      if (!m_idle) begin
        m_last = tl[0].a;
        void'(tl.pop_front());
      end
      if (m_idle && m_qn > 0) begin
        m_c = exp_q.pop_front();
        tl.push_back('{m_c[3+AW-1:AW], m_c[AW-1:0], m_c[3+AW-1:AW] != 3'd5});
        if (m_c[3+AW-1:AW] == 3'd5) tl.push_back('{3'd0, m_c[AW-1:0], 1'b1});
      end
      m_err = 1'b0;
      if (cmd_valid && m_qn < DEPTH) begin
        if (cmd_func >= 3'd6) m_err = 1'b1;
        else exp_q.push_back({cmd_func, cmd_addr});
      end
    end
  end

  // scoreboard compare, every falling edge
  always @(negedge clk) begin
    logic [2:0]    e_func;
    logic [AW-1:0] e_addr;
    logic          e_done;
    e_func = (tl.size() > 0) ? tl[0].f : 3'd0;
    e_addr = (tl.size() > 0) ? tl[0].a : m_last;
    e_done = (tl.size() > 0) ? tl[0].d : 1'b0;
    chk("cyc_func", 32'(func), 32'(e_func));
    chk("cyc_addr", 32'(addr), 32'(e_addr));
    chk("cyc_done", 32'(done), 32'(e_done));
    chk("cyc_err", 32'(err), 32'(m_err));
    chk("cyc_busy", 32'(busy), 32'((exp_q.size() > 0) || (tl.size() > 0)));
    chk("cyc_ready", 32'(cmd_ready), 32'(exp_q.size() < DEPTH));
    if (done === 1'b1) done_cnt++;
    if (err === 1'b1) err_cnt++;
  end

  // driver tasks: start just after a rising edge, return on the accepting rising edge
  task automatic push(input logic [2:0] f, input logic [AW-1:0] a);
    bit acc;
    acc = 1'b0;
    last_tries = 0;
    #1;
    cmd_valid = 1'b1;
    cmd_func  = f;
    cmd_addr  = a;
    for (int i = 0; i < 50 && !acc; i++) begin
      @(negedge clk);
      acc = cmd_ready;
      if (!acc) saw_full = 1'b1;
      last_tries++;
      @(posedge clk);
    end
    if (!acc) begin
      checks++;
      errors++;
      $display("FAIL push_timeout: cmd_ready stayed 0 for 50 cycles, required 1");
    end
  endtask

  task automatic release_cmd();
    #1;
    cmd_valid = 1'b0;
    cmd_func  = 3'd0;
    cmd_addr  = '0;
  endtask

  task automatic wait_idle();
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 200 && !ok; i++) begin
      @(negedge clk);
      if (busy === 1'b0) ok = 1'b1;
    end
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL wait_idle: busy still %0b after 200 cycles, required 0", busy);
    end
    @(posedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    // reset values
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ready", 32'(cmd_ready), 32'd1);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_func", 32'(func), 32'd0);
    chk("rst_addr", 32'(addr), 32'd0);
    n_reset = 1'b1;
    @(posedge clk);

    // single legal command: visible one cycle, done in that cycle
    push(3'd2, 8'h12);
    release_cmd();
    @(posedge clk);
    #2;
    chk("c2_func", 32'(func), 32'd2);
    chk("c2_addr", 32'(addr), 32'h12);
    chk("c2_done", 32'(done), 32'd1);
    @(posedge clk);
    #2;
    chk("c2_func_after", 32'(func), 32'd0);
    chk("c2_addr_after", 32'(addr), 32'h12);
    chk("c2_done_after", 32'(done), 32'd0);
    chk("c2_busy_after", 32'(busy), 32'd0);
    @(posedge clk);

    // code 5: issue, hold with done, idle
    push(3'd5, 8'h40);
    release_cmd();
    @(posedge clk);
    #2;
    chk("c5_func", 32'(func), 32'd5);
    chk("c5_addr", 32'(addr), 32'h40);
    chk("c5_done_issue", 32'(done), 32'd0);
    @(posedge clk);
    #2;
    chk("c5_hold_func", 32'(func), 32'd0);
    chk("c5_hold_addr", 32'(addr), 32'h40);
    chk("c5_hold_done", 32'(done), 32'd1);
    chk("c5_hold_state", 32'(dbg_state), 32'd2);
    @(posedge clk);
    #2;
    chk("c5_idle_done", 32'(done), 32'd0);
    chk("c5_idle_busy", 32'(busy), 32'd0);
    chk("c5_idle_addr", 32'(addr), 32'h40);
    @(posedge clk);

    // back-to-back pushes while stalled behind code 5 commands: FIFO fills
    base = done_cnt;
    saw_full = 1'b0;
    push(3'd5, 8'h50);
    push(3'd5, 8'h51);
    push(3'd1, 8'h52);
    push(3'd2, 8'h53);
    push(3'd3, 8'h54);
    push(3'd4, 8'h55);
    push(3'd0, 8'h56);
    release_cmd();
    chk("fill_ready_dropped", 32'(saw_full), 32'd1);
    wait_idle();
    chk("fill_done_count", 32'(done_cnt - base), 32'd7);

    // illegal codes are discarded with an err pulse
    base = err_cnt;
    push(3'd6, 8'h33);
    #2;
    chk("ill6_err", 32'(err), 32'd1);
    chk("ill6_busy", 32'(busy), 32'd0);
    chk("ill6_ready", 32'(cmd_ready), 32'd1);
    chk("ill6_func", 32'(func), 32'd0);
    push(3'd7, 8'h34);
    #2;
    chk("ill7_err", 32'(err), 32'd1);
    chk("ill7_busy", 32'(busy), 32'd0);
    release_cmd();
    @(posedge clk);
    #2;
    chk("ill_err_clear", 32'(err), 32'd0);
    @(posedge clk);
    chk("ill_err_pulses", 32'(err_cnt - base), 32'd2);

    // reset during HOLD with two entries queued
    push(3'd5, 8'h60);
    push(3'd1, 8'h61);
    push(3'd2, 8'h62);
    release_cmd();
    chk("mid_state_hold", 32'(dbg_state), 32'd2);
    #1;
    n_reset = 1'b0;
    base = done_cnt;
    #1;
    chk("mid_rst_func", 32'(func), 32'd0);
    chk("mid_rst_addr", 32'(addr), 32'd0);
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_done", 32'(done), 32'd0);
    chk("mid_rst_ready", 32'(cmd_ready), 32'd1);
    repeat (2) @(posedge clk);
    #1;
    n_reset = 1'b1;
    repeat (5) @(posedge clk);
    chk("mid_no_done", 32'(done_cnt - base), 32'd0);
    chk("mid_no_issue_busy", 32'(busy), 32'd0);

    // first command after reset is taken on the first edge
    push(3'd3, 8'h70);
    chk("post_rst_tries", 32'(last_tries), 32'd1);
    release_cmd();
    wait_idle();

    // continuous push while popping: 20 commands, pointer wrap
    base = done_cnt;
    for (int i = 0; i < 20; i++) push(3'(i % 6), 8'(8'h80 + i));
    release_cmd();
    wait_idle();
    chk("stream_done_count", 32'(done_cnt - base), 32'd20);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
